display_serial_tx: RTL and testbench

Parametrised serialiser driving an N-digit shift-register 7-segment display chain.
- Converts packed BCD (plus per-digit decimal points) to segment bytes.
- Optionally blanks leading zeros.
- Shifts the frame out on a generated serial clock, then pulses a latch strobe.
- Sits between the calculator result/BCD path and the external display pins; frames are started by a start/busy/done handshake rather than free-running.

---
 rtl/display_serial_tx.sv | 156 +++++++++++++++
 tb/tb_display_serial_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/display_serial_tx.sv
// Serialiser for an N-digit shift-register 7-segment chain: BCD -> segments, shift, latch.
// Define DISP_HEX_EN to show nibbles 10..15 as hex glyphs instead of a dash.
module display_serial_tx #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 1,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_latch,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned FRAME_W = 8 * NUM_DIGITS;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned PH_W    = $clog2(2 * CLK_DIV);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH    = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  logic [BIT_W-1:0]   bit_q;
  logic [PH_W-1:0]    phase_q;

  function automatic logic [7:0] seg_encode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
`ifdef DISP_HEX_EN
      4'd10:   s = 8'hEE;
      4'd11:   s = 8'h3E;
      4'd12:   s = 8'h9C;
      4'd13:   s = 8'h7A;
      4'd14:   s = 8'h9E;
      default: s = 8'h8E;
`else
      default: s = 8'h02;
`endif
    endcase
    return s;
  endfunction

  // Transmission order is fixed by LSB_FIRST; idx is the count of bits already sent.
  function automatic logic frame_bit(input logic [FRAME_W-1:0] f, input logic [BIT_W-1:0] idx);
    return LSB_FIRST ? f[idx] : f[BIT_LAST - idx];
  endfunction

  logic       lead;
  logic [3:0] digit;
  logic [7:0] seg_b;

  // Scan from the most significant digit; zeros are blanked until the first nonzero digit.
  always_comb begin
    frame_d = '0;
    lead    = blank_lz;
    digit   = '0;
    seg_b   = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      digit = bcd_in[4*i +: 4];
      seg_b = seg_encode(digit);
      if (lead && (i != 0) && (digit == 4'd0)) begin
        seg_b = 8'h00;
      end else begin
        lead = 1'b0;
      end
      seg_b[0]           = seg_b[0] | dp_in[i];
      frame_d[8*i +: 8]  = seg_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      bit_q     <= '0;
      phase_q   <= '0;
      ser_data  <= 1'b0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          ser_data  <= 1'b0;
          ser_clk   <= 1'b0;
          ser_latch <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            frame_q  <= frame_d;
            bit_q    <= '0;
            phase_q  <= '0;
            busy     <= 1'b1;
            ser_data <= frame_bit(frame_d, '0);
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (phase_q == PH_LAST) begin
            phase_q <= '0;
            ser_clk <= 1'b0;
            if (bit_q == BIT_LAST) begin
              state_q   <= StLatch;
              ser_latch <= 1'b1;
              ser_data  <= 1'b0;
            end else begin
              bit_q    <= bit_q + 1'b1;
              ser_data <= frame_bit(frame_q, bit_q + 1'b1);
            end
          end else begin
            phase_q <= phase_q + 1'b1;
            ser_clk <= ((phase_q + 1'b1) >= PH_HIGH);
          end
        end
        StLatch: begin
          // phase_q is reused to time the latch strobe.
          if (phase_q == LATCH_LAST) begin
            state_q   <= StIdle;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            phase_q   <= '0;
            bit_q     <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_display_serial_tx.sv
// Randomised self-checking bench for display_serial_tx with two parameter sets
// (A: 4 digits, CLK_DIV=1, LSB first; B: 2 digits, CLK_DIV=3, MSB first).
module tb_display_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_blz, a_data, a_sclk, a_latch, a_busy, a_done;
  logic [15:0] a_bcd;
  logic [3:0]  a_dp;
  logic        b_start, b_blz, b_data, b_sclk, b_latch, b_busy, b_done;
  logic [7:0]  b_bcd;
  logic [1:0]  b_dp;

  display_serial_tx #(.NUM_DIGITS(4), .CLK_DIV(1), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .bcd_in(a_bcd), .dp_in(a_dp), .blank_lz(a_blz),
    .ser_data(a_data), .ser_clk(a_sclk), .ser_latch(a_latch), .busy(a_busy), .done(a_done)
  );

  display_serial_tx #(.NUM_DIGITS(2), .CLK_DIV(3), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .bcd_in(b_bcd), .dp_in(b_dp), .blank_lz(b_blz),
    .ser_data(b_data), .ser_clk(b_sclk), .ser_latch(b_latch), .busy(b_busy), .done(b_done)
  );

  bit   sel_g;
  logic m_data, m_sclk, m_latch, m_busy, m_done;
  assign m_data  = sel_g ? b_data  : a_data;
  assign m_sclk  = sel_g ? b_sclk  : a_sclk;
  assign m_latch = sel_g ? b_latch : a_latch;
  assign m_busy  = sel_g ? b_busy  : a_busy;
  assign m_done  = sel_g ? b_done  : a_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] pend_bcd;
  logic [7:0]  pend_dp;
  bit          pend_blz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] seg(input logic [3:0] v);
    case (v)
      0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
      4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
      8: return 8'hFE;  9: return 8'hF6;
`ifdef DISP_HEX_EN
      10: return 8'hEE; 11: return 8'h3E; 12: return 8'h9C;
      13: return 8'h7A; 14: return 8'h9E; default: return 8'h8E;
`else
      default: return 8'h02;
`endif
    endcase
  endfunction

  function automatic logic [31:0] model(input int n, input logic [31:0] bcd,
                                        input logic [7:0] dp, input bit blz);
    logic [31:0] f;
    logic [3:0]  d;
    logic [7:0]  s;
    bit          lead;
    f    = '0;
    lead = blz;
    for (int i = n - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      s = seg(d);
      if (lead && i > 0 && d == 0) s = 8'h00;
      else lead = 0;
      s[0] = s[0] | dp[i];
      f[8*i +: 8] = s;
    end
    return f;
  endfunction

  task automatic drive(input bit sel, input logic [31:0] bcd, input logic [7:0] dp,
                       input bit blz, input bit st);
    if (sel) begin
      b_bcd = bcd[7:0]; b_dp = dp[1:0]; b_blz = blz; b_start = st;
    end else begin
      a_bcd = bcd[15:0]; a_dp = dp[3:0]; a_blz = blz; a_start = st;
    end
  endtask

  // mode 0: plain frame, 1: start re-pulsed mid-frame, 2: reset at act_t,
  // 3: end at done and issue pend_* start in the done cycle, 4: continue a chained start.
  task automatic run_frame(input bit sel, input logic [31:0] bcd, input logic [7:0] dp,
                           input bit blz, input logic [31:0] exp, input int mode,
                           input int act_t);
    int n, cd, total, lim, k, rises, highs, busyc, latchc, donec, done_t, viol;
    bit lsb, prev_clk, prev_data;
    logic [31:0] word;
    n = sel ? 2 : 4;  cd = sel ? 3 : 1;  lsb = !sel;
    total = 16 * n * cd + cd;
    lim = total + 3;
    sel_g = sel;
    word = '0; k = 0; rises = 0; highs = 0; busyc = 0; latchc = 0; donec = 0;
    done_t = 0; viol = 0; prev_clk = 0; prev_data = 0;
    if (mode != 4) begin
      @(negedge clk);
      drive(sel, bcd, dp, blz, 1'b1);
    end
    @(negedge clk);
    a_start = 0; b_start = 0;
    for (int t = 1; t <= lim; t++) begin
      if (t > 1) @(negedge clk);
      if (t == 1) check("first_bit", 32'(m_data), 32'(lsb ? exp[0] : exp[8*n-1]));
      if (m_busy) busyc++;
      if (m_latch) latchc++;
      if (m_latch && m_data) viol++;
      if (m_sclk) highs++;
      if (m_sclk && !prev_clk) begin
        if (k < 8 * n) begin
          if (lsb) word[k] = m_data;
          else word[8*n-1-k] = m_data;
        end
        k++;
        rises++;
      end
      if (t > 1 && m_data !== prev_data && !(prev_clk && !m_sclk)) viol++;
      if (m_done) begin
        donec++;
        done_t = t;
      end
      prev_clk = m_sclk;
      prev_data = m_data;
      if (mode == 1 && t == act_t) drive(sel, $urandom, 8'($urandom), 1'($urandom), 1'b1);
      if (mode == 1 && t == act_t + 1) begin a_start = 0; b_start = 0; end
      if (mode == 2 && t == act_t) begin
        rst = 1;
        drive(sel, bcd, dp, blz, 1'b1);
      end
      if (mode == 2 && t == act_t + 1) begin
        check("rst_outputs", 32'({m_data, m_sclk, m_latch, m_busy, m_done}), 32'd0);
        rst = 0; a_start = 0; b_start = 0;
        busyc = 0; latchc = 0; donec = 0;
      end
      if (mode == 3 && m_done) begin
        drive(sel, pend_bcd, pend_dp, pend_blz, 1'b1);
        break;
      end
    end
    if (mode == 2) begin
      check("rst_busy_after", busyc, 0);
      check("rst_no_latch", latchc, 0);
      check("rst_no_done", donec, 0);
    end else begin
      check("frame", word, exp);
      check("rises", rises, 8 * n);
      check("clk_high_cycles", highs, 8 * n * cd);
      check("busy_cycles", busyc, total);
      check("latch_cycles", latchc, cd);
      check("done_pulses", donec, 1);
      check("done_time", done_t, total + 1);
      check("data_timing", viol, 0);
    end
  endtask

  initial begin
    logic [31:0] bcd, exp;
    logic [7:0]  dp;
    bit          blz, sel;
    int          n, z;
    rst = 1;
    a_start = 0; a_bcd = '0; a_dp = '0; a_blz = 0;
    b_start = 0; b_bcd = '0; b_dp = '0; b_blz = 0;
    sel_g = 0;
    repeat (3) @(negedge clk);
    check("reset_a", 32'({a_data, a_sclk, a_latch, a_busy, a_done}), 32'd0);
    check("reset_b", 32'({b_data, b_sclk, b_latch, b_busy, b_done}), 32'd0);
    rst = 0;

    run_frame(0, 32'h1234, 8'h0, 0, 32'h60DAF266, 0, 0);
    run_frame(0, 32'h0070, 8'h0, 1, 32'h0000E0FC, 0, 0);
    run_frame(0, 32'h0000, 8'h0, 1, 32'h000000FC, 0, 0);
    run_frame(0, 32'h0070, 8'h0, 0, 32'hFCFCE0FC, 0, 0);
    run_frame(0, 32'h1234, 8'h1, 0, 32'h60DAF267, 0, 0);
`ifdef DISP_HEX_EN
    run_frame(0, 32'h00A0, 8'h0, 0, 32'hFCFCEEFC, 0, 0);
`else
    run_frame(0, 32'h00A0, 8'h0, 0, 32'hFCFC02FC, 0, 0);
`endif
    run_frame(1, 32'h12, 8'h0, 0, 32'h60DA, 0, 0);
    run_frame(0, 32'h5678, 8'h0, 0, 32'hB6BEE0FE, 1, 10);
    run_frame(1, 32'h90, 8'h2, 1, 32'hF7FC, 1, 40);

    pend_bcd = 32'h0409; pend_dp = 8'h4; pend_blz = 1;
    run_frame(0, 32'h2468, 8'h0, 0, 32'hDA66BEFE, 3, 0);
    run_frame(0, pend_bcd, pend_dp, pend_blz, model(4, pend_bcd, pend_dp, pend_blz), 4, 0);

    run_frame(0, 32'h1234, 8'h0, 0, 32'h60DAF266, 2, 21);
    run_frame(0, 32'h9876, 8'h0, 0, 32'hF6FEE0BE, 0, 0);

    for (int it = 0; it < 24; it++) begin
      sel = it[0];
      n = sel ? 2 : 4;
      bcd = $urandom;
      z = $urandom_range(0, n - 1);
      for (int j = n - 1; j > n - 1 - z; j--) bcd[4*j +: 4] = 4'h0;
      dp = 8'($urandom);
      blz = 1'($urandom_range(0, 1));
      exp = model(n, bcd, dp, blz);
      run_frame(sel, bcd, dp, blz, exp, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
